// File: rtl/tt_briscv_pkg.sv
// Shared load-queue types for the briscv core: entry info record, queue
// geometry and per-entry lifecycle state.
package tt_briscv_pkg;

   localparam int LQ_DEPTH      = 8;
   localparam int LQ_DEPTH_LOG2 = $clog2(LQ_DEPTH);

   typedef struct packed {
      logic        load;
      logic        vec_load;
      logic        sign_ext;
      logic [1:0]  size;
      logic [4:0]  rd;
      logic [15:0] pc;
   } lq_info_s;

   typedef enum logic [1:0] {
      LQ_FREE = 2'd0,
      LQ_PEND = 2'd1,
      LQ_DONE = 2'd2
   } lq_state_e;

   // Only loads wait for a memory response; everything else completes at allocation.
   function automatic logic needs_resp(input lq_info_s info);
      return info.load | info.vec_load;
   endfunction

endpackage

// File: rtl/tt_lq_retire_ctrl.sv
// Load-queue retire controller: circular buffer of entries allocated at the
// tail, completed out of order by memory responses, retired in order at the head.
module tt_lq_retire_ctrl
   import tt_briscv_pkg::*;
#(
   parameter int DEPTH = LQ_DEPTH,
   parameter int DW    = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   input  logic           i_alloc_vld,
   input  lq_info_s       i_alloc_info,
   output logic           o_alloc_rdy,
   output logic [AW-1:0]  o_alloc_lqid,
   input  logic           i_resp_vld,
   input  logic [AW-1:0]  i_resp_lqid,
   input  logic [DW-1:0]  i_resp_data,
   output logic           o_ret_vld,
   input  logic           i_ret_rdy,
   output lq_info_s       o_ret_info,
   output logic [DW-1:0]  o_ret_data,
   output logic [AW-1:0]  o_ret_lqid,
   input  logic           i_flush,
   output logic [AW:0]    o_count,
   output logic           o_empty,
   output logic           o_full,
   output logic           o_resp_err
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Pointers carry one wrap bit above the index so full and empty differ.
   logic [AW:0]   head_r, tail_r, head_nxt, tail_nxt;
   lq_state_e     state_r   [DEPTH];
   lq_state_e     state_nxt [DEPTH];
   lq_info_s      info_mem  [DEPTH];
   logic [DW-1:0] data_mem  [DEPTH];
   logic          resp_err_r, resp_err_nxt;

   logic [AW-1:0] head_idx_s, tail_idx_s;
   logic [AW:0]   count_s;
   logic          full_s, ret_vld_s;
   logic          alloc_fire_s, ret_fire_s, resp_bad_s, resp_ok_s;

   assign head_idx_s   = head_r[AW-1:0];
   assign tail_idx_s   = tail_r[AW-1:0];
   assign count_s      = tail_r - head_r;
   assign full_s       = (count_s == FULL_CNT);
   assign ret_vld_s    = (state_r[head_idx_s] == LQ_DONE);
   assign alloc_fire_s = i_alloc_vld & ~full_s;
   assign ret_fire_s   = ret_vld_s & i_ret_rdy;
   // A response racing the allocation of its own entry is treated as stray.
   assign resp_bad_s   = i_resp_vld &
                         ((state_r[i_resp_lqid] != LQ_PEND) |
                          (alloc_fire_s & (i_resp_lqid == tail_idx_s)));
   assign resp_ok_s    = i_resp_vld & ~resp_bad_s;

   // State register: pointers, per-entry state and sticky error flag.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         head_r     <= '0;
         tail_r     <= '0;
         resp_err_r <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            state_r[i] <= LQ_FREE;
         end
      end else begin
         head_r     <= head_nxt;
         tail_r     <= tail_nxt;
         resp_err_r <= resp_err_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            state_r[i] <= state_nxt[i];
         end
      end
   end

   // Next-state logic: flush overrides allocate, response and retire.
   always_comb begin
      head_nxt     = head_r;
      tail_nxt     = tail_r;
      resp_err_nxt = resp_err_r;
      for (int i = 0; i < DEPTH; i++) begin
         state_nxt[i] = state_r[i];
      end
      if (i_flush) begin
         head_nxt = '0;
         tail_nxt = '0;
         for (int i = 0; i < DEPTH; i++) begin
            state_nxt[i] = LQ_FREE;
         end
      end else begin
         if (alloc_fire_s) begin
            state_nxt[tail_idx_s] = needs_resp(i_alloc_info) ? LQ_PEND : LQ_DONE;
            tail_nxt              = tail_r + {{AW{1'b0}}, 1'b1};
         end else begin
            tail_nxt = tail_r;
         end
         if (resp_ok_s) begin
            state_nxt[i_resp_lqid] = LQ_DONE;
         end else begin
            resp_err_nxt = resp_err_r | resp_bad_s;
         end
         if (ret_fire_s) begin
            state_nxt[head_idx_s] = LQ_FREE;
            head_nxt              = head_r + {{AW{1'b0}}, 1'b1};
         end else begin
            head_nxt = head_r;
         end
      end
   end

   // Entry payload storage; only ever observed once the entry reaches DONE.
   always_ff @(posedge i_clk) begin
      if (!i_flush) begin
         if (alloc_fire_s) begin
            info_mem[tail_idx_s] <= i_alloc_info;
            data_mem[tail_idx_s] <= '0;
         end
         if (resp_ok_s) begin
            data_mem[i_resp_lqid] <= i_resp_data;
         end
      end
   end

   // Output decode from registered state only; payload masked while not valid.
   always_comb begin
      o_ret_vld    = ret_vld_s;
      o_ret_lqid   = head_idx_s;
      o_alloc_lqid = tail_idx_s;
      o_count      = count_s;
      o_full       = full_s;
      o_empty      = (count_s == '0);
      o_alloc_rdy  = ~full_s;
      o_resp_err   = resp_err_r;
      if (ret_vld_s) begin
         o_ret_info = info_mem[head_idx_s];
         o_ret_data = data_mem[head_idx_s];
      end else begin
         o_ret_info = '0;
         o_ret_data = '0;
      end
   end

endmodule

// File: tb/tb_tt_lq_retire_ctrl.sv
// Directed bench for tt_lq_retire_ctrl: in-order retire, full/wrap, stores,
// stray responses, flush priority and asynchronous reset.
module tb_tt_lq_retire_ctrl;
   import tt_briscv_pkg::*;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           alloc_vld;
   lq_info_s       alloc_info;
   logic           alloc_rdy;
   logic [2:0]     alloc_lqid;
   logic           resp_vld;
   logic [2:0]     resp_lqid;
   logic [31:0]    resp_data;
   logic           ret_vld;
   logic           ret_rdy;
   lq_info_s       ret_info;
   logic [31:0]    ret_data;
   logic [2:0]     ret_lqid;
   logic           flush;
   logic [3:0]     count;
   logic           empty, full, resp_err;

   int vectors = 0;
   int errs    = 0;

   tt_lq_retire_ctrl dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_alloc_vld(alloc_vld), .i_alloc_info(alloc_info),
      .o_alloc_rdy(alloc_rdy), .o_alloc_lqid(alloc_lqid),
      .i_resp_vld(resp_vld), .i_resp_lqid(resp_lqid), .i_resp_data(resp_data),
      .o_ret_vld(ret_vld), .i_ret_rdy(ret_rdy),
      .o_ret_info(ret_info), .o_ret_data(ret_data), .o_ret_lqid(ret_lqid),
      .i_flush(flush), .o_count(count), .o_empty(empty), .o_full(full),
      .o_resp_err(resp_err)
   );

   always #5 clk = ~clk;

   function automatic lq_info_s mk(input logic ld, input logic [15:0] pc);
      lq_info_s r;
      r          = '0;
      r.load     = ld;
      r.rd       = pc[4:0];
      r.pc       = pc;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; alloc_vld = 1'b0; alloc_info = '0; resp_vld = 1'b0;
      resp_lqid = 3'd0; resp_data = 32'd0; ret_rdy = 1'b0; flush = 1'b0;
      #12;
      chk("rst_count",    64'(count),     64'd0);
      chk("rst_empty",    64'(empty),     64'd1);
      chk("rst_full",     64'(full),      64'd0);
      chk("rst_rdy",      64'(alloc_rdy), 64'd1);
      chk("rst_ret_vld",  64'(ret_vld),   64'd0);
      chk("rst_ret_data", 64'(ret_data),  64'd0);
      chk("rst_ret_info", 64'(ret_info),  64'd0);
      chk("rst_lqid",     64'(alloc_lqid),64'd0);
      chk("rst_err",      64'(resp_err),  64'd0);
      rst_n = 1'b1;
      tick();

      // Three loads, responses out of order, retire in order.
      ret_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("alloc_lqid", 64'(alloc_lqid), 64'(i));
         alloc_vld = 1'b1; alloc_info = mk(1'b1, 16'h100 + 16'(i));
         tick();
      end
      alloc_vld = 1'b0;
      chk("three_count", 64'(count), 64'd3);
      resp_vld = 1'b1; resp_lqid = 3'd2; resp_data = 32'hA2;
      tick();
      chk("blocked_vld", 64'(ret_vld), 64'd0);
      chk("blocked_cnt", 64'(count),   64'd3);
      resp_lqid = 3'd0; resp_data = 32'hA0; ret_rdy = 1'b0;
      tick();
      chk("ret0_vld",  64'(ret_vld),  64'd1);
      chk("ret0_lqid", 64'(ret_lqid), 64'd0);
      chk("ret0_data", 64'(ret_data), 64'hA0);
      chk("ret0_info", 64'(ret_info), 64'(mk(1'b1, 16'h100)));
      resp_lqid = 3'd1; resp_data = 32'hA1; ret_rdy = 1'b1;
      tick();
      resp_vld = 1'b0;
      chk("ret1_lqid", 64'(ret_lqid), 64'd1);
      chk("ret1_data", 64'(ret_data), 64'hA1);
      tick();
      chk("ret2_lqid", 64'(ret_lqid), 64'd2);
      chk("ret2_data", 64'(ret_data), 64'hA2);
      tick();
      ret_rdy = 1'b0;
      chk("drain_empty", 64'(empty),    64'd1);
      chk("drain_err",   64'(resp_err), 64'd0);

      // Store completes at allocation with zero data.
      alloc_vld = 1'b1; alloc_info = mk(1'b0, 16'h200);
      tick();
      alloc_vld = 1'b0;
      chk("store_vld",  64'(ret_vld),  64'd1);
      chk("store_data", 64'(ret_data), 64'd0);
      chk("store_lqid", 64'(ret_lqid), 64'd3);
      ret_rdy = 1'b1;
      tick();
      ret_rdy = 1'b0;
      chk("store_ret", 64'(count), 64'd0);

      // Fill to eight, wrap around after one retire.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_lqid", 64'(alloc_lqid), 64'd0);
      alloc_vld = 1'b1; alloc_info = mk(1'b1, 16'h300);
      for (int i = 0; i < 8; i++) tick();
      chk("full_flag",  64'(full),      64'd1);
      chk("full_rdy",   64'(alloc_rdy), 64'd0);
      chk("full_count", 64'(count),     64'd8);
      tick();
      chk("full_hold",  64'(count),     64'd8);
      alloc_vld = 1'b0;
      resp_vld = 1'b1; resp_lqid = 3'd0; resp_data = 32'h55;
      tick();
      resp_vld = 1'b0;
      chk("full_ret_vld", 64'(ret_vld),  64'd1);
      chk("full_ret_dat", 64'(ret_data), 64'h55);
      ret_rdy = 1'b1; alloc_vld = 1'b1;
      tick();
      ret_rdy = 1'b0;
      chk("nobypass_cnt", 64'(count),      64'd7);
      chk("rdy_back",     64'(alloc_rdy),  64'd1);
      chk("wrap_lqid",    64'(alloc_lqid), 64'd0);
      tick();
      alloc_vld = 1'b0;
      chk("wrap_count", 64'(count),   64'd8);
      chk("wrap_head",  64'(ret_lqid),64'd1);

      // Stray response to a FREE entry.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      resp_vld = 1'b1; resp_lqid = 3'd5; resp_data = 32'hDEAD;
      tick();
      resp_vld = 1'b0;
      chk("stray_err",   64'(resp_err), 64'd1);
      chk("stray_count", 64'(count),    64'd0);
      chk("stray_vld",   64'(ret_vld),  64'd0);
      tick(); tick();
      chk("sticky_err",  64'(resp_err), 64'd1);

      // Flush beats simultaneous allocate and response.
      alloc_vld = 1'b1; alloc_info = mk(1'b1, 16'h400);
      for (int i = 0; i < 4; i++) tick();
      chk("occ4", 64'(count), 64'd4);
      flush = 1'b1; resp_vld = 1'b1; resp_lqid = 3'd0;
      tick();
      flush = 1'b0; resp_vld = 1'b0; alloc_vld = 1'b0;
      chk("fl_count", 64'(count),      64'd0);
      chk("fl_empty", 64'(empty),      64'd1);
      chk("fl_lqid",  64'(alloc_lqid), 64'd0);
      chk("fl_err",   64'(resp_err),   64'd1);

      // Asynchronous reset mid-stream.
      alloc_vld = 1'b1; alloc_info = mk(1'b0, 16'h500);
      tick();
      alloc_vld = 1'b0;
      chk("pre_rst_vld", 64'(ret_vld), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld",   64'(ret_vld),   64'd0);
      chk("arst_count", 64'(count),     64'd0);
      chk("arst_err",   64'(resp_err),  64'd0);
      chk("arst_rdy",   64'(alloc_rdy), 64'd1);
      rst_n = 1'b1;
      tick();

      // Response colliding with allocation of the same entry.
      alloc_vld = 1'b1; alloc_info = mk(1'b1, 16'h600);
      resp_vld = 1'b1; resp_lqid = 3'd0; resp_data = 32'h99;
      tick();
      alloc_vld = 1'b0;
      chk("race_err", 64'(resp_err), 64'd1);
      chk("race_cnt", 64'(count),    64'd1);
      chk("race_vld", 64'(ret_vld),  64'd0);
      resp_data = 32'h77;
      tick();
      resp_vld = 1'b0;
      chk("late_vld",  64'(ret_vld),  64'd1);
      chk("late_data", 64'(ret_data), 64'h77);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
